// File: rtl/apb_slave_regfile.sv
// APB responder terminating bridge transfers into a bank of 32-bit registers.
// Index 0 is a read-only ID register. Wait states come from WAIT_STATES; errors are
// signalled through pslverr for a bad address or a write to the ID register.
//
// Ports:
//   hclk, hresetn           bridge clock, asynchronous active-low reset
//   psel, penable, pwrite   APB control from the bridge (this slave's pselx bit)
//   paddr, pwdata           byte address / write data, latched while in SETUP
//   prdata                  read data, non-zero only in a successful read completion
//   pready                  transfer completes this cycle
//   pslverr                 error response, only ever high together with pready
module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;

  // Slot 0 is never stored: it is the constant ID register.
  logic [31:0] regs_q [1:NUM_REGS-1];

  logic [9:0]  idx;
  logic        err;
  logic        access_ok;
  logic        commit;
  logic [31:0] rd_val;

  // All decode works from the copy latched in SETUP, so the bus may move afterwards.
  assign idx = addr_q[11:2];

  always_comb begin
    err = 1'b0;
    if (addr_q[31:12] != BASE_ADDR[31:12])  err = 1'b1;
    if (addr_q[1:0] != 2'b00)               err = 1'b1;
    if ({1'b0, idx} >= 11'(NUM_REGS))       err = 1'b1;
    if (write_q && (idx == 10'd0))          err = 1'b1;
  end

  // Dropping psel in the completing cycle aborts the transfer: no pready, no write.
  assign access_ok = (state_q == ST_ACCESS) && psel;
  assign commit    = access_ok && write_q && !err;

  always_comb begin
    rd_val = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == 10'(i)) rd_val = regs_q[i];
    end
  end

  assign pready  = access_ok;
  assign pslverr = access_ok && err;
  assign prdata  = (access_ok && !write_q && !err) ? rd_val : 32'h0;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      ST_IDLE: begin
        // penable without a preceding setup cycle is ignored here.
        if (psel && !penable) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        addr_d  = paddr;
        wdata_d = pwdata;
        write_d = pwrite;
        wcnt_d  = 4'(WAIT_STATES);
        state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A new setup seen in the completing cycle chains straight into SETUP.
        if (psel && !penable) state_d = ST_SETUP;
        else                  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
    end else if (commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx == 10'(i)) regs_q[i] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances (0, 2 and 3 wait states) share
// the APB bus; each has its own psel bit. Expected values are hand-computed constants.
module tb_apb_slave_regfile;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [2:0]  psel_v = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;

  logic [31:0] prdata_0, prdata_2, prdata_3;
  logic        pready_0, pready_2, pready_3;
  logic        pslverr_0, pslverr_2, pslverr_3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  apb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_0), .pready(pready_0), .pslverr(pslverr_0)
  );
  apb_slave_regfile #(.WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_2), .pready(pready_2), .pslverr(pslverr_2)
  );
  apb_slave_regfile #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_3), .pready(pready_3), .pslverr(pslverr_3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return pready_0;
      1:       return pready_2;
      default: return pready_3;
    endcase
  endfunction

  function automatic logic err_of(input int d);
    case (d)
      0:       return pslverr_0;
      1:       return pslverr_2;
      default: return pslverr_3;
    endcase
  endfunction

  function automatic logic [31:0] rd_of(input int d);
    case (d)
      0:       return prdata_0;
      1:       return prdata_2;
      default: return prdata_3;
    endcase
  endfunction

  // Drive the setup phase in the current cycle (no clock consumed).
  task automatic apb_setup(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    psel_v    = 3'b000;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
  endtask

  // Run the access phase until pready; returns at the negedge of the completing cycle.
  // cycles counts clocks from the setup cycle to the completing cycle.
  task automatic apb_finish(input int d, input bit scramble, input string tag,
                            output logic [31:0] rd, output logic err, output int cycles);
    bit done = 0;
    bit err_early = 0;
    @(posedge hclk); #1;
    penable = 1'b1;
    cycles  = 1;
    rd      = 32'h0;
    err     = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge hclk);
      if (rdy_of(d)) begin
        rd   = rd_of(d);
        err  = err_of(d);
        done = 1;
      end else begin
        if (err_of(d) || rd_of(d) != 32'h0) err_early = 1;
        @(posedge hclk); #1;
        cycles++;
        if (scramble) begin
          pwdata = ~pwdata;
          paddr  = paddr ^ 32'h4;
        end
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      cycles = -1;
    end
    chk({tag, "_quiet_while_waiting"}, {31'd0, err_early}, 32'd0);
  endtask

  task automatic apb_release();
    @(posedge hclk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input bit scramble, input string tag,
                          output logic [31:0] rd, output logic err, output int cycles);
    @(posedge hclk); #1;
    apb_setup(d, wr, a, wd);
    apb_finish(d, scramble, tag, rd, err, cycles);
    apb_release();
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    // Reset state
    #12;
    chk("rst_pready0", {31'd0, pready_0}, 32'd0);
    chk("rst_pslverr0", {31'd0, pslverr_0}, 32'd0);
    chk("rst_prdata0", prdata_0, 32'h0);
    chk("rst_pready3", {31'd0, pready_3}, 32'd0);
    hresetn = 1'b1;
    repeat (2) @(posedge hclk);

    apb_xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, "rst_reg1", rd, er, cyc);
    chk("rst_reg1_data", rd, 32'h0);

    // 1: zero wait states, write then read back
    apb_xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 0, "t1_wr", rd, er, cyc);
    chk("t1_wr_cycles", cyc, 32'd2);
    chk("t1_wr_err", {31'd0, er}, 32'd0);
    chk("t1_wr_prdata", rd, 32'h0);
    apb_xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, "t1_rd", rd, er, cyc);
    chk("t1_rd_cycles", cyc, 32'd2);
    chk("t1_rd_data", rd, 32'hDEAD_BEEF);
    chk("t1_rd_err", {31'd0, er}, 32'd0);

    // 2: three wait states, ID register
    apb_xfer(2, 1'b0, 32'h8000_0000, 32'h0, 0, "t2_id", rd, er, cyc);
    chk("t2_id_cycles", cyc, 32'd5);
    chk("t2_id_data", rd, 32'hA5B0_0001);
    chk("t2_id_err", {31'd0, er}, 32'd0);

    // Latched copy is used even if the bus moves during the wait states
    apb_xfer(2, 1'b1, 32'h8000_0014, 32'h0BAD_F00D, 1, "t2_scr_wr", rd, er, cyc);
    chk("t2_scr_wr_err", {31'd0, er}, 32'd0);
    apb_xfer(2, 1'b0, 32'h8000_0014, 32'h0, 0, "t2_scr_rd", rd, er, cyc);
    chk("t2_scr_rd_data", rd, 32'h0BAD_F00D);

    // 3: illegal writes all error, nothing changes
    apb_xfer(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "t3_id", rd, er, cyc);
    chk("t3_id_err", {31'd0, er}, 32'd1);
    chk("t3_id_cycles", cyc, 32'd2);
    apb_xfer(0, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 0, "t3_idx16", rd, er, cyc);
    chk("t3_idx16_err", {31'd0, er}, 32'd1);
    apb_xfer(0, 1'b1, 32'h8000_0006, 32'hFFFF_FFFF, 0, "t3_unal", rd, er, cyc);
    chk("t3_unal_err", {31'd0, er}, 32'd1);
    apb_xfer(0, 1'b1, 32'h9000_0004, 32'hFFFF_FFFF, 0, "t3_base", rd, er, cyc);
    chk("t3_base_err", {31'd0, er}, 32'd1);
    apb_xfer(0, 1'b0, 32'h8000_0000, 32'h0, 0, "t3_rb_id", rd, er, cyc);
    chk("t3_rb_id_data", rd, 32'hA5B0_0001);
    apb_xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, "t3_rb_r1", rd, er, cyc);
    chk("t3_rb_r1_data", rd, 32'hDEAD_BEEF);
    chk("t3_rb_r1_err", {31'd0, er}, 32'd0);
    apb_xfer(0, 1'b0, 32'h8000_0040, 32'h0, 0, "t3_rd16", rd, er, cyc);
    chk("t3_rd16_err", {31'd0, er}, 32'd1);
    chk("t3_rd16_data", rd, 32'h0);

    // 4: two wait states, psel dropped in the first WAIT cycle
    @(posedge hclk); #1;
    apb_setup(1, 1'b1, 32'h8000_000C, 32'h5555_AAAA);
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
    @(negedge hclk);
    chk("t4_abort_pready", {31'd0, pready_2}, 32'd0);
    repeat (3) @(negedge hclk);
    chk("t4_after_pready", {31'd0, pready_2}, 32'd0);
    apb_xfer(1, 1'b0, 32'h8000_000C, 32'h0, 0, "t4_rd", rd, er, cyc);
    chk("t4_rd_cycles", cyc, 32'd4);
    chk("t4_rd_data", rd, 32'h0);

    // 5: back-to-back write then read with no idle cycle
    @(posedge hclk); #1;
    apb_setup(0, 1'b1, 32'h8000_0004, 32'hCAFE_0001);
    apb_finish(0, 0, "t5_wr", rd, er, cyc);
    chk("t5_wr_cycles", cyc, 32'd2);
    apb_setup(0, 1'b0, 32'h8000_0004, 32'h0);
    apb_finish(0, 0, "t5_rd", rd, er, cyc);
    chk("t5_rd_cycles", cyc, 32'd2);
    chk("t5_rd_data", rd, 32'hCAFE_0001);
    apb_release();

    // 6: reset pulsed mid-WAIT on a write
    @(posedge hclk); #1;
    apb_setup(1, 1'b1, 32'h8000_0008, 32'h1234_5678);
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    chk("t6_pready", {31'd0, pready_2}, 32'd0);
    chk("t6_pslverr", {31'd0, pslverr_2}, 32'd0);
    chk("t6_prdata", prdata_2, 32'h0);
    psel_v  = 3'b000;
    penable = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    apb_xfer(1, 1'b0, 32'h8000_0008, 32'h0, 0, "t6_rd", rd, er, cyc);
    chk("t6_rd_data", rd, 32'h0);
    chk("t6_rd_cycles", cyc, 32'd4);
    apb_xfer(0, 1'b0, 32'h8000_0004, 32'h0, 0, "t6_ws0_r1", rd, er, cyc);
    chk("t6_ws0_r1_data", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
